conv11_window_gen: RTL and testbench
====================================

// Module: conv11_window_gen
// PURPOSE
//  Producer side of the conv11 3x3 window handshake. Accepts a raster-order pixel stream
//  (one pixel/cycle max) and emits every valid 3x3 window (stride 1, no padding).
//  Sits between the feature-map source and the conv11 window input stage.
//  Window outputs connect to that stage's in_r_c ports; valid_out/ready_in form the handshake.
// PARAMETERS
//  DATA_WIDTH  8   pixel width in bits
//  IMG_W       28  frame width in pixels (>=3)
//  IMG_H       28  frame height in pixels (>=3)
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           async reset, active low
//  start        in   1           1-cycle pulse: begin new frame (honoured only in IDLE)
//  pix_valid    in   1           pixel present on pix_in
//  pix_in       in   DATA_WIDTH  raster-order pixel
//  pix_ready    out  1           block accepts pixel this cycle
//  valid_out    out  1           win_* holds a valid window
//  ready_in     in   1           consumer accepts window this cycle
//  win_r_c      out  DATA_WIDTH  9 ports, r,c in {0,1,2}: win_r_c = pixel(row-2+r, col-2+c)
//  busy         out  1           frame in progress (not IDLE)
//  frame_done   out  1           1-cycle pulse when last window is accepted
// BEHAVIOUR
//  Reset: state=IDLE; row/col counters, line buffers, 3x3 shift regs, win_* all 0;
//   pix_ready=0, valid_out=0, busy=0, frame_done=0.
//  FSM: IDLE -start-> RUN; RUN -last pixel (IMG_H-1,IMG_W-1) accepted-> DRAIN;
//   DRAIN -valid_out&&ready_in-> IDLE with frame_done=1. start outside IDLE ignored.
//  Pixel accept: pix_valid && pix_ready. pix_ready = (state==RUN) && (!valid_out || ready_in).
//  On accept: col++ (wrap at IMG_W-1 to 0, row++); pixel pushed into line buffer 0,
//   line buffer 0 tail to line buffer 1; 3x3 regs shift left, right column loaded with
//   {lb1 out, lb0 out, pix_in} as rows {0,1,2}.
//  Window emit: accepted pixel at row>=2 && col>=2 -> win_* and valid_out=1 next cycle.
//   Latency 1 cycle pixel-accept -> valid_out.
//  Hold: while valid_out && !ready_in, win_* and valid_out stable; no pixel accepted.
//  valid_out clears on ready_in unless a new window is loaded the same cycle.
//   Back-to-back accept+emit then gives 1 window/cycle.
//  Column wrap: cols 0,1 of each row refill the shift regs and emit nothing.
//   Window count per frame = (IMG_W-2)*(IMG_H-2).
//  Rows 0,1 only fill line buffers; no windows.
//  Async reset mid-frame: immediate return to reset values; the partial frame is discarded.
//  Counters sized $clog2(IMG_W), $clog2(IMG_H); no arithmetic on pixel data.
// STRUCTURE
//  conv11_pkg: state enum (IDLE/RUN/DRAIN), CNT_W functions.
//  Sub-module conv11_line_buffer (depth IMG_W-?:
//   IMG_W-entry shift FIFO, shift-enable = pixel accept), instantiated twice.
//  Top: FSM, row/col counters, 3x3 shift regs, output register + handshake.
// TESTING
//  4x4 frame, pix_in=0..15, ready_in=1 -> 4 windows, in order.
//   W0 = 0,1,2/4,5,6/8,9,10; W3 = 5,6,7/9,10,11/13,14,15; frame_done after W3.
//  Same frame, ready_in low 5 cycles at W1 -> W1 held stable; pix_ready=0 during stall.
//   No pixel lost; sequence identical to case 1.
//  28x28 ramp (pix=(r*28+c)&8'hFF), random pix_valid/ready_in -> exactly 676 windows.
//   Each matches golden model.
//  start pulsed mid-frame -> ignored, window sequence unchanged.
//  rst_n low after 10 windows -> all outputs 0 immediately.
//   A new start + full frame then produces a correct sequence from W0.
//  pix_valid=1 continuous, ready_in=1 -> valid_out 1 every cycle for cols 2..IMG_W-1.
//   Exactly 2-cycle gap at each row wrap.

Source files
------------

// File: rtl/conv11_pkg.sv
// rtl/conv11_pkg.sv - shared types and sizing helpers for the conv11 window generator
package conv11_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv11_line_buffer.sv
// rtl/conv11_line_buffer.sv - fixed-depth shift FIFO holding one image row
module conv11_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (shift_en) begin
      mem_d = {mem_q[DEPTH-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Tail is the pixel pushed DEPTH accepts ago: same column, one row up.
  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv11_window_gen.sv
// rtl/conv11_window_gen.sv - raster pixel stream to stride-1 3x3 window stream
module conv11_window_gen
  import conv11_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic                  pix_ready,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] win_0_0,
  output logic [DATA_WIDTH-1:0] win_0_1,
  output logic [DATA_WIDTH-1:0] win_0_2,
  output logic [DATA_WIDTH-1:0] win_1_0,
  output logic [DATA_WIDTH-1:0] win_1_1,
  output logic [DATA_WIDTH-1:0] win_1_2,
  output logic [DATA_WIDTH-1:0] win_2_0,
  output logic [DATA_WIDTH-1:0] win_2_1,
  output logic [DATA_WIDTH-1:0] win_2_2,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  state_t                              state_q, state_d;
  logic [ROW_W-1:0]                    row_q, row_d;
  logic [COL_W-1:0]                    col_q, col_d;
  logic [2:0][2:0][DATA_WIDTH-1:0]     sr_q, sr_d;
  logic [2:0][2:0][DATA_WIDTH-1:0]     win_q, win_d;
  logic                                valid_q, valid_d;
  logic                                accept;
  logic                                emit;
  logic [DATA_WIDTH-1:0]               lb0_out, lb1_out;

  conv11_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_W)
  ) u_lb0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .din      (pix_in),
    .dout     (lb0_out)
  );

  conv11_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_W)
  ) u_lb1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .din      (lb0_out),
    .dout     (lb1_out)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    sr_d       = sr_q;
    win_d      = win_q;
    frame_done = 1'b0;

    // A held window blocks new pixels so the output register is never overwritten.
    pix_ready = (state_q == ST_RUN) && (!valid_q || ready_in);
    accept    = pix_valid && pix_ready;
    emit      = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    valid_d   = emit ? 1'b1 : (ready_in ? 1'b0 : valid_q);

    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        sr_d[r][0] = sr_q[r][1];
        sr_d[r][1] = sr_q[r][2];
      end
      sr_d[0][2] = lb1_out;
      sr_d[1][2] = lb0_out;
      sr_d[2][2] = pix_in;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (emit) begin
      win_d = sr_d;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_RUN: begin
        if (accept && (row_q == ROW_LAST) && (col_q == COL_LAST)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (valid_q && ready_in) begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      sr_q    <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sr_q    <= sr_d;
      win_q   <= win_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign valid_out = valid_q;
  assign win_0_0   = win_q[0][0];
  assign win_0_1   = win_q[0][1];
  assign win_0_2   = win_q[0][2];
  assign win_1_0   = win_q[1][0];
  assign win_1_1   = win_q[1][1];
  assign win_1_2   = win_q[1][2];
  assign win_2_0   = win_q[2][0];
  assign win_2_1   = win_q[2][1];
  assign win_2_2   = win_q[2][2];

endmodule

// File: tb/tb_conv11_window_gen.sv
// tb/tb_conv11_window_gen.sv - scoreboard bench for conv11_window_gen on 4x4 and 28x28 frames
module tb_conv11_window_gen;

  localparam logic [71:0] W0_4X4 = 72'h00_01_02_04_05_06_08_09_0A;
  localparam logic [71:0] W3_4X4 = 72'h05_06_07_09_0A_0B_0D_0E_0F;

  typedef struct {
    logic [71:0] win;
    int          col;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, start28;
  logic       pix_valid;
  logic [7:0] pix_in;
  logic       ready_in;

  logic       pr4, vo4, busy4, fd4;
  logic       pr28, vo28, busy28, fd28;
  logic [7:0] a4 [9];
  logic [7:0] a28 [9];

  logic        sel;
  logic        pr_m, vo_m, busy_m, fd_m;
  logic [71:0] win_m;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  conv11_window_gen #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pr4), .valid_out(vo4), .ready_in(ready_in),
    .win_0_0(a4[0]), .win_0_1(a4[1]), .win_0_2(a4[2]),
    .win_1_0(a4[3]), .win_1_1(a4[4]), .win_1_2(a4[5]),
    .win_2_0(a4[6]), .win_2_1(a4[7]), .win_2_2(a4[8]),
    .busy(busy4), .frame_done(fd4)
  );

  conv11_window_gen #(.DATA_WIDTH(8), .IMG_W(28), .IMG_H(28)) dut28 (
    .clk(clk), .rst_n(rst_n), .start(start28), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pr28), .valid_out(vo28), .ready_in(ready_in),
    .win_0_0(a28[0]), .win_0_1(a28[1]), .win_0_2(a28[2]),
    .win_1_0(a28[3]), .win_1_1(a28[4]), .win_1_2(a28[5]),
    .win_2_0(a28[6]), .win_2_1(a28[7]), .win_2_2(a28[8]),
    .busy(busy28), .frame_done(fd28)
  );

  always_comb begin
    pr_m   = sel ? pr28   : pr4;
    vo_m   = sel ? vo28   : vo4;
    busy_m = sel ? busy28 : busy4;
    fd_m   = sel ? fd28   : fd4;
    win_m  = '0;
    for (int i = 0; i < 9; i++) begin
      win_m[71-8*i -: 8] = sel ? a28[i] : a4[i];
    end
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c, input int w, input int off);
    return 8'((r * w + c + off) & 255);
  endfunction

  function automatic logic [71:0] exp_win(input int r, input int c, input int w, input int off);
    logic [71:0] res;
    res = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        res[71-8*(i*3+j) -: 8] = pix(r - 2 + i, c - 2 + j, w, off);
    return res;
  endfunction

  task automatic drive_start(input logic v);
    if (sel) start28 = v;
    else     start4  = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 72'(vo_m), 72'(0));
    check({tag, "_win"}, win_m, 72'(0));
    check({tag, "_pix_ready"}, 72'(pr_m), 72'(0));
    check({tag, "_busy"}, 72'(busy_m), 72'(0));
    check({tag, "_frame_done"}, 72'(fd_m), 72'(0));
  endtask

  task automatic run_frame(input int w, input int h, input int off, input bit rnd,
                           input bit stall, input bit midstart, input bit abort,
                           input bit gapchk);
    int   idx, pops, total, stall_left, last_pop, fd_spurious, r, c;
    bit   stalled, aborted;
    exp_t e;
    sel         = (w == 28);
    total       = (w - 2) * (h - 2);
    idx         = 0;
    pops        = 0;
    stall_left  = 5;
    last_pop    = 0;
    fd_spurious = 0;
    aborted     = 1'b0;
    sb.delete();

    @(negedge clk);
    pix_valid = 1'b0;
    ready_in  = 1'b1;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    #1 check("busy_after_start", 72'(busy_m), 72'(1));

    for (int cyc = 0; cyc < 20000 && pops < total && !aborted; cyc++) begin
      @(negedge clk);
      drive_start(midstart && cyc == 40);
      pix_valid = (idx < w * h) && (!rnd || $urandom_range(0, 3) != 0);
      pix_in    = pix_valid ? pix(idx / w, idx % w, w, off) : 8'($urandom);
      ready_in  = !rnd || $urandom_range(0, 3) != 0;
      stalled   = stall && pops == 1 && vo_m && stall_left > 0;
      if (stalled) begin
        ready_in = 1'b0;
        stall_left--;
      end
      #1;
      if (stalled) begin
        check("stall_pix_ready", 72'(pr_m), 72'(0));
        if (sb.size() > 0) check("stall_hold", win_m, sb[0].win);
      end
      if (pix_valid && pr_m) begin
        r = idx / w;
        c = idx % w;
        if (r >= 2 && c >= 2) sb.push_back('{exp_win(r, c, w, off), c});
        idx++;
      end
      if (vo_m && ready_in) begin
        if (sb.size() == 0) begin
          check("unexpected_window", 72'(1), 72'(0));
        end else begin
          e = sb.pop_front();
          check("window", win_m, e.win);
          check("frame_done", 72'(fd_m), 72'(pops == total - 1));
          if (w == 4 && pops == 0) check("w0_4x4", win_m, W0_4X4);
          if (w == 4 && pops == 3) check("w3_4x4", win_m, W3_4X4);
          if (gapchk && pops > 0) check("emit_gap", 72'(cyc - last_pop), 72'((e.col == 2) ? 3 : 1));
        end
        last_pop = cyc;
        pops++;
      end else if (fd_m) begin
        fd_spurious++;
      end
      if (abort && pops == 10) begin
        pix_valid = 1'b0;
        rst_n     = 1'b0;
        #1 check_reset_outputs("abort_rst");
        @(negedge clk);
        rst_n   = 1'b1;
        aborted = 1'b1;
      end
    end

    if (!aborted) begin
      check("window_count", 72'(pops), 72'(total));
      check("spurious_frame_done", 72'(fd_spurious), 72'(0));
      pix_valid = 1'b0;
      @(negedge clk);
      #1 check("busy_after_frame", 72'(busy_m), 72'(0));
      check("scoreboard_drained", 72'(sb.size()), 72'(0));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start4    = 1'b0;
    start28   = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    ready_in  = 1'b1;
    sel       = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset4");
    sel = 1'b1;
    #1 check_reset_outputs("reset28");
    @(negedge clk);
    rst_n = 1'b1;

    //        w   h   off rnd stall mid abort gap
    run_frame(4,  4,  0,  0,  0,    0,  0,    0);
    run_frame(4,  4,  0,  0,  1,    0,  0,    0);
    run_frame(28, 28, 0,  1,  0,    0,  0,    0);
    run_frame(28, 28, 3,  0,  0,    1,  0,    0);
    run_frame(28, 28, 0,  0,  0,    0,  1,    0);
    run_frame(28, 28, 7,  1,  0,    0,  0,    0);
    run_frame(28, 28, 0,  0,  0,    0,  0,    1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
